p405s_dcd_inst_queue: RTL

Parametrised decode-and-queue stage between the instruction fetch buffer and the execute stage. It accepts up to LANES instructions per cycle and pre-decodes each one into a 16-bit class-flag vector. It holds decoded instructions in a DEPTH-entry in-order queue and issues one per cycle under an execute-hold handshake. After issuing a context-synchronising instruction, it stops issue until execute reports completion.

---
 rtl/p405s_dcd_inst_queue.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/p405s_dcd_inst_queue.sv
// p405s_dcd_inst_queue
//   Decode-and-queue stage between the instruction fetch buffer and execute.
//   Up to LANES instructions per cycle are pre-decoded into a 16-bit class
//   flag vector and stored in a DEPTH-entry in-order queue. The head is
//   issued under an execute-hold handshake. Issue stops after a
//   context-synchronising instruction (rfi/sc/isync) until syncDone.
//
// Ports
//   CB         clock
//   resetCore  synchronous active-high reset
//   ifbInst    LANES x 32-bit instructions, lane 0 in [31:0] and oldest
//   ifbValid   per-lane valid (lane 1 only with lane 0)
//   dcdRdy     queue has room for LANES entries this cycle
//   dcdInst    head instruction (registered)
//   dcdFlags   head decode flags (registered)
//   dcdValid   head valid (registered)
//   exeHold    execute stall; transfer = dcdValid & ~exeHold
//   syncDone   synchronising instruction completed (one-cycle pulse)
//   dcdFlush   discard everything queued and held
//   dcdCount   queue occupancy
//
// Build option
//   P405S_DCD_APU_EN  when defined, primary opcode 4 decodes as an APU
//                     instruction (flag 15) instead of a MAC form (flag 0).
module p405s_dcd_inst_queue #(
  parameter int unsigned LANES = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     CB,
  input  logic                     resetCore,
  input  logic [32*LANES-1:0]      ifbInst,
  input  logic [LANES-1:0]         ifbValid,
  output logic                     dcdRdy,
  output logic [31:0]              dcdInst,
  output logic [15:0]              dcdFlags,
  output logic                     dcdValid,
  input  logic                     exeHold,
  input  logic                     syncDone,
  input  logic                     dcdFlush,
  output logic [$clog2(DEPTH):0]   dcdCount
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {
    ST_RUN,
    ST_SYNC
  } state_e;

  // IBM numbering: inst[0:5] = bits 31:26, inst[21:30] = bits 10:1,
  // inst[22:30] = bits 9:1, Rc = inst[31] = bit 0, inst[30] = bit 1.
  function automatic logic [15:0] decode(input logic [31:0] inst);
    logic [5:0]  po;
    logic [9:0]  xo;
    logic [8:0]  xo9;
    logic        rc;
    logic [15:0] f;
    po  = inst[31:26];
    xo  = inst[10:1];
    xo9 = inst[9:1];
    rc  = inst[0];
    f   = '0;
    f[0]  = (po == 6'd7) ||
            ((po == 6'd31) && (xo9 inside {9'd11, 9'd75, 9'd235, 9'd459, 9'd491}));
`ifdef P405S_DCD_APU_EN
    f[15] = (po == 6'd4);
`else
    f[0]  = f[0] || (po == 6'd4);
`endif
    f[2]  = (po == 6'd31) && (xo == 10'd467);
    f[3]  = (po == 6'd31) && ((xo == 10'd339) || (xo == 10'd323));
    f[4]  = (po == 6'd18);
    f[5]  = (po == 6'd16) || ((po == 6'd19) && ((xo == 10'd16) || (xo == 10'd528)));
    f[6]  = (po == 6'd19) &&
            (xo inside {10'd33, 10'd129, 10'd193, 10'd225, 10'd257, 10'd289, 10'd417, 10'd449});
    f[7]  = (po == 6'd19) && (xo == 10'd0);
    f[8]  = (po == 6'd31) && (xo == 10'd512);
    f[9]  = (po == 6'd31) && (xo == 10'd144);
    f[10] = (po == 6'd31) && (xo == 10'd150) && rc;
    f[11] = (po == 6'd31) && (xo == 10'd914);
    f[12] = (po == 6'd19) && ((xo == 10'd50) || (xo == 10'd51));
    f[13] = (po == 6'd17) && inst[1];
    f[14] = (po == 6'd19) && (xo == 10'd150);
    // CR-field enable covers compares plus the CR writers decoded above.
    f[1]  = (po == 6'd10) || (po == 6'd11) || (|f[9:6]);
    return f;
  endfunction

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [47:0]     mem_q [DEPTH];
  logic [47:0]     mem_d [DEPTH];
  logic [31:0]     dcd_inst_q, dcd_inst_d;
  logic [15:0]     dcd_flags_q, dcd_flags_d;
  logic            dcd_valid_q, dcd_valid_d;

  logic            rdy;
  logic            accept;
  logic            xfer;
  logic [PW-1:0]   wr_slot;
  logic [CW-1:0]   n_enq;

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    n_enq    = '0;
    wr_slot  = wr_ptr_q;

    rdy    = (CW'(DEPTH) - count_q) >= CW'(LANES);
    accept = rdy && !dcdFlush;
    xfer   = dcd_valid_q && !exeHold;

    for (int unsigned l = 0; l < LANES; l++) begin
      if (accept && ifbValid[l]) begin
        mem_d[wr_slot] = {ifbInst[32*l +: 32], decode(ifbInst[32*l +: 32])};
        wr_slot        = wr_slot + PW'(1);
        n_enq          = n_enq + CW'(1);
      end
    end
    wr_ptr_d = wr_slot;

    // Issue is impossible in SYNC (valid forced low), so a transfer and
    // a meaningful syncDone never coincide.
    if (xfer) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      if (|dcd_flags_q[14:12]) state_d = ST_SYNC;
    end else if ((state_q == ST_SYNC) && syncDone) begin
      state_d = ST_RUN;
    end

    count_d = count_q + n_enq - CW'(xfer);

    if (dcdFlush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      state_d  = ST_RUN;
    end

    // Output register tracks the next-cycle head, including an entry
    // written into an empty queue this cycle.
    {dcd_inst_d, dcd_flags_d} = mem_d[rd_ptr_d];
    dcd_valid_d = (count_d != '0) && (state_d == ST_RUN);
  end

  always_ff @(posedge CB) begin
    if (resetCore) begin
      state_q     <= ST_RUN;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      dcd_inst_q  <= '0;
      dcd_flags_q <= '0;
      dcd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      dcd_inst_q  <= dcd_inst_d;
      dcd_flags_q <= dcd_flags_d;
      dcd_valid_q <= dcd_valid_d;
    end
  end

  // Storage needs no reset: it is only observed through the counted head.
  always_ff @(posedge CB) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  assign dcdRdy   = rdy;
  assign dcdInst  = dcd_inst_q;
  assign dcdFlags = dcd_flags_q;
  assign dcdValid = dcd_valid_q;
  assign dcdCount = count_q;

endmodule
